// File: rtl/comp_edge_resolve_n.sv
// N-channel edge race resolver: reports the first (MODE 0) or last (MODE 1) arriving channel
// within a MAX_T-cycle window. Defining COMP_EDGE_RESOLVE_TIE_EN adds the `tie` output.
`timescale 1ns/1ps
module comp_edge_resolve_n #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned MAX_T = 15,
   parameter int unsigned MODE  = 0,
   parameter int unsigned T_W   = $clog2(MAX_T + 1),
   parameter int unsigned IDX_W = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_CH-1:0]  edge_in,
   input  logic             result_ready,
   output logic             busy,
   output logic             result_valid,
   output logic [IDX_W-1:0] winner_idx,
   output logic [N_CH-1:0]  winner_onehot,
   output logic [T_W-1:0]   winner_time,
   output logic [N_CH-1:0]  arrived,
   output logic             timeout
`ifdef COMP_EDGE_RESOLVE_TIE_EN
   ,
   output logic             tie
`endif
);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_CH-1:0]   prev_q;
   logic [T_W-1:0]    t_q, t_d;
   logic [N_CH-1:0]   arrived_q, arrived_d;
   logic [IDX_W-1:0]  win_idx_q, win_idx_d;
   logic [N_CH-1:0]   win_oh_q, win_oh_d;
   logic [T_W-1:0]    win_time_q, win_time_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
   logic              tie_q, tie_d;
`endif

   logic [N_CH-1:0]   fresh, fresh_low, arr_all;
   logic [IDX_W-1:0]  fresh_idx;
   logic              fresh_multi, take;

   // Only rising edges on channels that have not yet arrived count in this window.
   always_comb begin
      fresh       = edge_in & ~prev_q & ~arrived_q;
      arr_all     = arrived_q | fresh;
      fresh_low   = fresh & (~fresh + N_CH'(1));
      fresh_multi = (fresh & (fresh - N_CH'(1))) != '0;
      fresh_idx   = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (fresh[i-1]) fresh_idx = IDX_W'(i - 1);
      end
      if (MODE == 0) take = (arrived_q == '0) && (fresh != '0);
      else           take = (fresh != '0);
   end

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      arrived_d  = arrived_q;
      win_idx_d  = win_idx_q;
      win_oh_d   = win_oh_q;
      win_time_d = win_time_q;
      timeout_d  = timeout_q;
      busy_d     = busy_q;
      valid_d    = valid_q;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
      tie_d      = tie_q;
`endif
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               state_d    = ARMED;
               busy_d     = 1'b1;
               t_d        = '0;
               arrived_d  = '0;
               win_idx_d  = '0;
               win_oh_d   = '0;
               win_time_d = '0;
               timeout_d  = 1'b0;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
               tie_d      = 1'b0;
`endif
            end
         end
         ARMED: begin
            arrived_d = arr_all;
            if (take) begin
               win_idx_d  = fresh_idx;
               win_oh_d   = fresh_low;
               win_time_d = t_q;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
               tie_d      = fresh_multi;
`endif
            end
            if (&arr_all) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
            end else if (t_q == T_W'(MAX_T)) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               timeout_d = 1'b1;
               // With no arrival at all, the reported time is the window end.
               if (arr_all == '0) win_time_d = T_W'(MAX_T);
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prev_q     <= '0;
         t_q        <= '0;
         arrived_q  <= '0;
         win_idx_q  <= '0;
         win_oh_q   <= '0;
         win_time_q <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
         tie_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         prev_q     <= edge_in;
         t_q        <= t_d;
         arrived_q  <= arrived_d;
         win_idx_q  <= win_idx_d;
         win_oh_q   <= win_oh_d;
         win_time_q <= win_time_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
         tie_q      <= tie_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign result_valid  = valid_q;
   assign winner_idx    = win_idx_q;
   assign winner_onehot = win_oh_q;
   assign winner_time   = win_time_q;
   assign arrived       = arrived_q;
   assign timeout       = timeout_q;
`ifdef COMP_EDGE_RESOLVE_TIE_EN
   assign tie           = tie_q;
`endif

endmodule

// File: doc/comp_edge_resolve_n.md
Name: comp_edge_resolve_n

Overview:
- Parametrised successor of the two-input edge comparator: resolves the temporal race between N_CH edge-coded channels inside a clocked arbitration window.
- Reports the winning channel, its arrival time, the arrival map and a timeout flag.
- MODE selects first-arrival (min) or last-arrival (max) resolution.
- Sits between the LFSR/stochastic edge generators and the select mux of the comparator datapath.

Parameters:
- N_CH, 4, number of edge channels (>=2)
- MAX_T, 15, last window cycle index; the window closes with timeout when the counter reaches it
- MODE, 0, 0 = first arrival wins (min), 1 = last arrival wins (max)
- T_W, $clog2(MAX_T+1), derived width of the time counter and timestamp
- IDX_W, $clog2(N_CH), derived width of the winner index

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; opens a window when in IDLE
- edge_in  in  N_CH  level-coded edges, synchronous to clk; a 0->1 transition is an arrival
- result_ready  in  1  consumer accepts the result
- busy  out  1  high in ARMED and DONE
- result_valid  out  1  result held stable while high
- winner_idx  out  IDX_W  winning channel index
- winner_onehot  out  N_CH  one-hot of winner; all zero if no arrival
- winner_time  out  T_W  counter value at the winner's arrival
- arrived  out  N_CH  channels that arrived in this window
- timeout  out  1  window closed before all channels arrived

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counter 0; edge history register 0.
- Edge detect: rise[i] = edge_in[i] & ~prev[i]. prev updates every cycle in every state, so a channel already high at start never arrives.
- IDLE:
  - start=1 -> ARMED next cycle; counter, arrived, winner and timeout cleared.
  - result_valid=0.
- ARMED:
  - Counter t starts at 0 and increments by 1 per cycle, saturating at MAX_T.
  - Each cycle: arrived |= rise, with only non-arrived channels considered.
  - MODE 0: on the first cycle with any rise, winner = lowest index in rise, winner_time = t. Later rises update arrived only.
  - MODE 1: on every cycle with any new rise, winner = lowest index in that cycle's new rises, winner_time = t (overwrites).
  - Close conditions: all arrived (including the updates of the current cycle) -> DONE, timeout=0. Else t==MAX_T -> DONE, timeout=1; arrivals on the MAX_T cycle still count.
  - start is ignored.
- DONE:
  - result_valid=1; all result outputs frozen.
  - On result_ready=1 -> IDLE next cycle; outputs stay held until the next start. start is ignored.
- No-arrival timeout: winner_onehot=0, winner_idx=0, winner_time=MAX_T, arrived=0, timeout=1.
- Latency: result_valid rises the cycle after the closing cycle.
- Reset mid-window: immediate return to IDLE with all outputs cleared; no partial result is emitted.
- A rise on a channel already in arrived (after a fall and re-rise) is ignored.

Optional Feature:
- Macro: COMP_EDGE_RESOLVE_TIE_EN.
- Defined: adds output port tie (1 bit). It is set in DONE when more than one channel rose in the cycle that fixed the final winner. Cleared on start and on rst.
- Undefined: no tie port; ties resolve silently to the lowest index.

Test Plan (N_CH=4, MAX_T=15):
- MODE 0, start; ch2 rises at t=3, ch0 at t=5, ch1 and ch3 at t=7 -> next cycle result_valid=1, winner_idx=2, winner_onehot=4'b0100, winner_time=3, arrived=4'b1111, timeout=0.
- MODE 0, ch1 and ch3 rise together at t=4, others never -> at t=15 close: winner_idx=1, winner_time=4, arrived=4'b1010, timeout=1; tie=1 when TIE_EN is defined.
- No edges after start -> result_valid 16 cycles after ARMED entry, winner_onehot=0, winner_time=15, timeout=1.
- MODE 1: ch0@2, ch3@6, ch1@9, ch2@11 -> winner_idx=2, winner_time=11, timeout=0. ch0 held high before start (no arrival) -> arrived[0]=0, timeout=1.
- Hold result_ready=0 for 10 cycles in DONE and pulse start -> outputs stable, start ignored; result_ready=1 -> IDLE next cycle, busy=0.
- Assert rst at t=6 of a window with 2 arrivals -> all outputs 0 asynchronously; next start runs a clean window with correct results.
